// File: rtl/tick_gen_multi_pkg.sv
// Shared constants and elaboration-time helpers for the cascaded tick generator.
package tick_gen_multi_pkg;

  localparam int unsigned DEF_CLK_HZ  = 32'd50_000_000;
  localparam int unsigned DEF_BASE_HZ = 32'd1000;
  localparam int unsigned MAX_PACK_W  = 32'd512;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value - 32'd1;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if ((v >> i) != 32'd0) begin
        r = 32'(i) + 32'd1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Extracts slice idx of a packed ratio vector whose slices are width bits wide.
  function automatic int unsigned stage_ratio(input logic [MAX_PACK_W-1:0] packed_div,
                                              input int unsigned idx,
                                              input int unsigned width);
    logic [MAX_PACK_W-1:0] shifted;
    logic [31:0]           mask;
    shifted = packed_div >> (idx * width);
    if (width >= 32'd32) begin
      mask = 32'hFFFF_FFFF;
    end else begin
      mask = (32'd1 << width) - 32'd1;
    end
    return shifted[31:0] & mask;
  endfunction

endpackage

// File: rtl/tick_gen_multi_if.sv
// Control/status bundle between the tick generator and its consumer.
interface tick_gen_multi_if #(
  parameter int NUM_CH = 3,
  parameter int ACT_W  = 5,
  parameter int IDLE_W = 8
);
  logic              en;
  logic              sync_clr;
  logic [ACT_W-1:0]  activity;
  logic [IDLE_W-1:0] idle_sec;
  logic [NUM_CH-1:0] tick;
  logic              idle_pulse;
  logic              idle;

  modport master (output en, sync_clr, activity, idle_sec, input tick, idle_pulse, idle);
  modport slave  (input en, sync_clr, activity, idle_sec, output tick, idle_pulse, idle);
endinterface

// File: rtl/tick_gen_multi_div_stage.sv
// One divider stage: counts incoming strobes and emits every ratio-th one.
module tick_div_stage #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe_in,
  input  logic             clr,
  input  logic [DIV_W-1:0] ratio,
  output logic             strobe_out,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_r;
  logic             tick_r;

  assign strobe_out = strobe_in & (cnt_r == (ratio - DIV_W'(1)));
  assign tick       = tick_r;

  // Stage counter and registered tick; clr realigns the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= {DIV_W{1'b0}};
      tick_r <= 1'b0;
    end else if (clr) begin
      cnt_r  <= {DIV_W{1'b0}};
      tick_r <= 1'b0;
    end else begin
      tick_r <= strobe_out;
      if (strobe_out) begin
        cnt_r <= {DIV_W{1'b0}};
      end else if (strobe_in) begin
        cnt_r <= cnt_r + DIV_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end
endmodule

// File: rtl/tick_gen_multi.sv
// Cascaded time-base: prescaler -> divider chain, plus an idle timeout on the slowest tick.
module tick_gen_multi
  import tick_gen_multi_pkg::*;
#(
  parameter int unsigned                  CLK_HZ    = DEF_CLK_HZ,
  parameter int unsigned                  BASE_HZ   = DEF_BASE_HZ,
  parameter int                           NUM_CH    = 3,
  parameter int                           DIV_W     = 16,
  parameter logic [NUM_CH*DIV_W-1:0]      STAGE_DIV = {16'd100, 16'd10, 16'd0},
  parameter int                           ACT_W     = 5,
  parameter int                           IDLE_W    = 8
) (
  input logic           clk,
  input logic           rst,
  tick_gen_multi_if.slave bus
);
  localparam int unsigned PRE_DIV = CLK_HZ / BASE_HZ;
  localparam int          PRE_W   = int'(clog2(PRE_DIV));

  if ((CLK_HZ % BASE_HZ) != 32'd0) begin : g_bad_base
    $error("CLK_HZ must be a multiple of BASE_HZ");
  end
  if (PRE_DIV < 32'd2) begin : g_bad_pre
    $error("prescaler ratio must be at least 2");
  end
  if ((NUM_CH * DIV_W) > int'(MAX_PACK_W)) begin : g_bad_pack
    $error("STAGE_DIV too wide for ratio helper");
  end

  logic [PRE_W-1:0]  pre_cnt_r;
  logic              tick0_r;
  logic [NUM_CH-1:0] strobe_s;
  logic [NUM_CH-1:0] tick_s;
  logic [IDLE_W-1:0] idle_cnt_r;
  logic [IDLE_W:0]   idle_inc_s;
  logic              idle_r;
  logic              idle_pulse_r;

  // sync_clr suppresses strobes so no stage or the idle counter sees a tick that cycle.
  assign strobe_s[0] = bus.en & ~bus.sync_clr & (pre_cnt_r == PRE_W'(PRE_DIV - 32'd1));
  assign tick_s[0]   = tick0_r;

  // Prescaler counter and base tick register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_r <= {PRE_W{1'b0}};
      tick0_r   <= 1'b0;
    end else if (bus.sync_clr) begin
      pre_cnt_r <= {PRE_W{1'b0}};
      tick0_r   <= 1'b0;
    end else begin
      tick0_r <= strobe_s[0];
      if (strobe_s[0]) begin
        pre_cnt_r <= {PRE_W{1'b0}};
      end else if (bus.en) begin
        pre_cnt_r <= pre_cnt_r + PRE_W'(1);
      end else begin
        pre_cnt_r <= pre_cnt_r;
      end
    end
  end

  for (genvar i = 1; i < NUM_CH; i++) begin : g_stage
    localparam int unsigned DIV_I = stage_ratio(MAX_PACK_W'(STAGE_DIV), i, DIV_W);
    if (DIV_I == 32'd0) begin : g_bad_div
      $error("stage ratio must be non-zero");
    end
    tick_div_stage #(.DIV_W(DIV_W)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .strobe_in  (strobe_s[i-1]),
      .clr        (bus.sync_clr),
      .ratio      (DIV_W'(DIV_I)),
      .strobe_out (strobe_s[i]),
      .tick       (tick_s[i])
    );
  end

  assign idle_inc_s = {1'b0, idle_cnt_r} + (IDLE_W+1)'(1);

  // Idle timeout: counts slowest strobes since last activity; count freezes once idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_r   <= {IDLE_W{1'b0}};
      idle_r       <= 1'b0;
      idle_pulse_r <= 1'b0;
    end else if (|bus.activity) begin
      idle_cnt_r   <= {IDLE_W{1'b0}};
      idle_r       <= 1'b0;
      idle_pulse_r <= 1'b0;
    end else if (bus.idle_sec == {IDLE_W{1'b0}}) begin
      idle_cnt_r   <= {IDLE_W{1'b0}};
      idle_r       <= 1'b0;
      idle_pulse_r <= 1'b0;
    end else if (strobe_s[NUM_CH-1] && !idle_r) begin
      idle_cnt_r <= idle_inc_s[IDLE_W-1:0];
      if (idle_inc_s >= {1'b0, bus.idle_sec}) begin
        idle_r       <= 1'b1;
        idle_pulse_r <= 1'b1;
      end else begin
        idle_r       <= idle_r;
        idle_pulse_r <= 1'b0;
      end
    end else begin
      idle_cnt_r   <= idle_cnt_r;
      idle_r       <= idle_r;
      idle_pulse_r <= 1'b0;
    end
  end

  assign bus.tick       = tick_s;
  assign bus.idle       = idle_r;
  assign bus.idle_pulse = idle_pulse_r;
endmodule

// File: tb/tb_tick_gen_multi.sv
// Scoreboard bench for tick_gen_multi: PRE_DIV=10, ratios {4,2}, IDLE_W=4.
module tb_tick_gen_multi;
  localparam int NUM_CH = 3;
  localparam int DIV_W  = 16;
  localparam int ACT_W  = 5;
  localparam int IDLE_W = 4;
  localparam logic [NUM_CH*DIV_W-1:0] SDIV = {16'd4, 16'd2, 16'd0};

  typedef struct {
    int                cyc;
    logic [NUM_CH-1:0] tick;
    logic              pulse;
    logic              idle;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  tick_gen_multi_if #(.NUM_CH(NUM_CH), .ACT_W(ACT_W), .IDLE_W(IDLE_W)) bus ();

  tick_gen_multi #(
    .CLK_HZ(1000), .BASE_HZ(100), .NUM_CH(NUM_CH), .DIV_W(DIV_W),
    .STAGE_DIV(SDIV), .ACT_W(ACT_W), .IDLE_W(IDLE_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // cyc = number of clock edges since reset was released
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  function automatic logic [NUM_CH-1:0] pat(input int d);
    logic [NUM_CH-1:0] t;
    t = {(d % 80) == 0, (d % 20) == 0, 1'b1};
    return t;
  endfunction

  task automatic push(input int c, input logic [NUM_CH-1:0] t, input logic p, input logic i);
    exp_t e;
    e.cyc = c; e.tick = t; e.pulse = p; e.idle = i;
    sb.push_back(e);
  endtask

  // Monitor: every output event is popped against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.tick != '0 || bus.idle_pulse)) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event cyc=%0d tick=%b pulse=%b idle=%b", cyc, bus.tick, bus.idle_pulse, bus.idle);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.tick != bus.tick || e.pulse != bus.idle_pulse || e.idle != bus.idle) begin
          n_err++;
          $display("FAIL event got cyc=%0d tick=%b pulse=%b idle=%b, expected cyc=%0d tick=%b pulse=%b idle=%b",
                   cyc, bus.tick, bus.idle_pulse, bus.idle, e.cyc, e.tick, e.pulse, e.idle);
        end
      end
    end
  end

  // Leaves the bench just after the negedge preceding edge n, so inputs set now are sampled at edge n.
  task automatic at_cyc(input int n);
    do @(negedge clk); while (cyc != n - 1);
    #1;
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if (bus.tick != '0 || bus.idle_pulse !== 1'b0 || bus.idle !== 1'b0) begin
      n_err++;
      $display("FAIL %s got tick=%b pulse=%b idle=%b, expected all zero", name, bus.tick, bus.idle_pulse, bus.idle);
    end
  endtask

  task automatic do_reset(input logic [IDLE_W-1:0] isec);
    rst = 1'b1;
    bus.en = 1'b1;
    bus.sync_clr = 1'b0;
    bus.activity = '0;
    bus.idle_sec = isec;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    #1 rst = 1'b0;
  endtask

  task automatic end_phase(input int n, input string name);
    at_cyc(n);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_leftover got %0d pending events, expected 0 (next cyc=%0d)", name, sb.size(), sb[0].cyc);
    end
    sb.delete();
  endtask

  initial begin
    bus.en = 1'b0;
    bus.sync_clr = 1'b0;
    bus.activity = '0;
    bus.idle_sec = '0;

    // free-running cascade, idle disabled
    do_reset(4'd0);
    for (int c = 10; c <= 170; c += 10) push(c, pat(c), 1'b0, 1'b0);
    end_phase(175, "free_run");

    // freeze for edges 33..39 shifts everything by 7
    do_reset(4'd0);
    for (int c = 10; c <= 30; c += 10) push(c, pat(c), 1'b0, 1'b0);
    for (int c = 47; c <= 167; c += 10) push(c, pat(c - 7), 1'b0, 1'b0);
    at_cyc(33); bus.en = 1'b0;
    at_cyc(40); bus.en = 1'b1;
    end_phase(170, "freeze");

    // sync_clr at edge 35 realigns phase to that edge
    do_reset(4'd0);
    for (int c = 10; c <= 30; c += 10) push(c, pat(c), 1'b0, 1'b0);
    for (int c = 45; c <= 165; c += 10) push(c, pat(c - 35), 1'b0, 1'b0);
    at_cyc(35); bus.sync_clr = 1'b1;
    at_cyc(36); bus.sync_clr = 1'b0;
    end_phase(170, "sync_clr");

    // idle_sec=3: single expiry at the third slow tick, sticky afterwards
    do_reset(4'd3);
    for (int c = 10; c <= 420; c += 10) push(c, pat(c), c == 240, c >= 240);
    end_phase(425, "idle_expire");

    // activity at the would-expire strobe restarts the count
    do_reset(4'd3);
    for (int c = 10; c <= 480; c += 10) push(c, pat(c), c == 480, c >= 480);
    at_cyc(240); bus.activity = 5'b00100;
    at_cyc(241); bus.activity = 5'b00000;
    end_phase(485, "activity");

    // mid-run reset while idle
    do_reset(4'd3);
    for (int c = 10; c <= 240; c += 10) push(c, pat(c), c == 240, c >= 240);
    at_cyc(250);
    n_cmp++;
    if (bus.idle !== 1'b1) begin
      n_err++;
      $display("FAIL idle_before_rst got idle=%b, expected 1", bus.idle);
    end
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL pre_reset_leftover got %0d pending, expected 0", sb.size());
    end
    sb.delete();
    #1 rst = 1'b0;
    push(10, pat(10), 1'b0, 1'b0);
    push(20, pat(20), 1'b0, 1'b0);
    end_phase(25, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
